// File: rtl/tmds_align_controller.sv
// Per-channel TMDS word-alignment controller: steps each channel's bit-phase select
// until CTRL sync tokens arrive at a steady rate, holds it, and re-searches on sustained loss.
module tmds_align_controller #(
  parameter int PHASES     = 10,
  parameter int WINDOW     = 4096,
  parameter int MIN_TOKENS = 16,
  parameter int SETTLE     = 32,
  parameter int MISS_LIMIT = 4
) (
  input  logic       hdmi_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [9:0] d0,
  input  logic [9:0] d1,
  input  logic [9:0] d2,
  output logic [3:0] phase0,
  output logic [3:0] phase1,
  output logic [3:0] phase2,
  output logic [2:0] ch_locked,
  output logic       all_locked,
  output logic [7:0] relock_count
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int SET_W  = $clog2(SETTLE + 1);
  localparam int TOK_W  = $clog2(MIN_TOKENS + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {ST_SETTLE, ST_SEARCH, ST_LOCKED} state_t;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  logic [9:0] chan_word [3];
  logic [3:0] chan_phase [3];
  logic [2:0] locked_nxt;
  logic [2:0] drop;

  assign chan_word[0] = d0;
  assign chan_word[1] = d1;
  assign chan_word[2] = d2;
  assign phase0 = chan_phase[0];
  assign phase1 = chan_phase[1];
  assign phase2 = chan_phase[2];

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t              state_q, state_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [TOK_W-1:0]    tok_q, tok_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [3:0]          phase_q, phase_d, phase_adv;
    logic                locked_q, locked_d, drop_d;
    logic                tok, win_end, win_good;

    assign tok       = is_token(chan_word[g]);
    assign win_end   = (win_q == WIN_W'(WINDOW - 1));
    // The closing cycle's token counts towards the window total.
    assign win_good  = (tok_q == TOK_W'(MIN_TOKENS)) ||
                       (tok && (tok_q == TOK_W'(MIN_TOKENS - 1)));
    assign phase_adv = (phase_q == 4'(PHASES - 1)) ? 4'd0 : phase_q + 4'd1;

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      win_d    = win_q;
      tok_d    = tok_q;
      miss_d   = miss_q;
      phase_d  = phase_q;
      locked_d = locked_q;
      drop_d   = 1'b0;
      if (!enable) begin
        state_d  = ST_SETTLE;
        settle_d = '0;
        win_d    = '0;
        tok_d    = '0;
        miss_d   = '0;
        locked_d = 1'b0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_q == SET_W'(SETTLE - 1)) begin
              state_d  = ST_SEARCH;
              settle_d = '0;
              win_d    = '0;
              tok_d    = '0;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
          ST_SEARCH, ST_LOCKED: begin
            win_d = win_q + 1'b1;
            if (tok && (tok_q != TOK_W'(MIN_TOKENS))) tok_d = tok_q + 1'b1;
            if (win_end) begin
              win_d = '0;
              tok_d = '0;
              if (state_q == ST_SEARCH) begin
                if (win_good) begin
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                  miss_d   = '0;
                end else begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
                  phase_d  = phase_adv;
                end
              end else if (win_good) begin
                miss_d = '0;
              end else if (miss_q == MISS_W'(MISS_LIMIT - 1)) begin
                state_d  = ST_SETTLE;
                settle_d = '0;
                miss_d   = '0;
                locked_d = 1'b0;
                phase_d  = phase_adv;
                drop_d   = 1'b1;
              end else begin
                miss_d = miss_q + 1'b1;
              end
            end
          end
          default: state_d = ST_SETTLE;
        endcase
      end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= ST_SETTLE;
        settle_q <= '0;
        win_q    <= '0;
        tok_q    <= '0;
        miss_q   <= '0;
        phase_q  <= '0;
        locked_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        settle_q <= settle_d;
        win_q    <= win_d;
        tok_q    <= tok_d;
        miss_q   <= miss_d;
        phase_q  <= phase_d;
        locked_q <= locked_d;
      end
    end

    assign chan_phase[g] = phase_q;
    assign ch_locked[g]  = locked_q;
    assign locked_nxt[g] = locked_d;
    assign drop[g]       = drop_d;
  end

  logic [1:0] drop_sum;
  logic [8:0] relock_sum;

  assign drop_sum   = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
  assign relock_sum = {1'b0, relock_count} + {7'b0, drop_sum};

  // all_locked follows next-state lock so it moves on the same edge as ch_locked.
  always_ff @(posedge hdmi_clk or negedge reset_n) begin
    if (!reset_n) begin
      all_locked   <= 1'b0;
      relock_count <= '0;
    end else begin
      all_locked   <= &locked_nxt;
      relock_count <= relock_sum[8] ? 8'hFF : relock_sum[7:0];
    end
  end

endmodule

// File: tb/tb_tmds_align_controller.sv
// Directed bench for tmds_align_controller with small parameters; token patterns are
// scheduled per edge number counted from reset release, expectations hand-computed.
module tb_tmds_align_controller;
  localparam int PHASES = 10, WINDOW = 64, MIN_TOKENS = 4, SETTLE = 8, MISS_LIMIT = 2;

  logic       hdmi_clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [9:0] d0, d1, d2;
  logic [3:0] phase0, phase1, phase2;
  logic [2:0] ch_locked;
  logic       all_locked;
  logic [7:0] relock_count;

  tmds_align_controller #(
    .PHASES(PHASES), .WINDOW(WINDOW), .MIN_TOKENS(MIN_TOKENS),
    .SETTLE(SETTLE), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .hdmi_clk(hdmi_clk), .reset_n(reset_n), .enable(enable),
    .d0(d0), .d1(d1), .d2(d2),
    .phase0(phase0), .phase1(phase1), .phase2(phase2),
    .ch_locked(ch_locked), .all_locked(all_locked), .relock_count(relock_count)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  typedef enum int {M_IDLE, M_EVERY8, M_PHASE6, M_P3, M_LIST, M_UNLOCKED} mode_t;

  mode_t mode [3];
  int    list_e [4];
  int    cyc;
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  // Word presented to channel n for edge e; tokens rotate through all four CTRL codes.
  function automatic logic [9:0] word_for(input int n, input int e, input logic [3:0] ph,
                                          input logic lk);
    logic [9:0] codes [4];
    logic       hit;
    codes = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    case (mode[n])
      M_EVERY8:   hit = (e % 8 == 0);
      M_PHASE6:   hit = (e % 8 == 0) && (ph == 4'd6);
      M_P3:       hit = (e % 64 >= 1) && (e % 64 <= 3);
      M_LIST:     hit = (e == list_e[0]) || (e == list_e[1]) || (e == list_e[2]) || (e == list_e[3]);
      M_UNLOCKED: hit = (e % 8 == 0) && !lk;
      default:    hit = 1'b0;
    endcase
    return hit ? codes[((e >> 3) + e + n) % 4] : {6'b110000, 4'(e)};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      d0 = word_for(0, cyc + 1, phase0, ch_locked[0]);
      d1 = word_for(1, cyc + 1, phase1, ch_locked[1]);
      d2 = word_for(2, cyc + 1, phase2, ch_locked[2]);
      @(posedge hdmi_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    d0 = 10'h300; d1 = 10'h300; d2 = 10'h300;
    repeat (2) @(posedge hdmi_clk);
    #1;
    check("rst_phases", {20'b0, phase0, phase1, phase2}, 32'h000);
    check("rst_flags", {ch_locked, all_locked, relock_count}, 32'h0);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    list_e = '{0, 0, 0, 0};

    // 1: steady tokens on d0 only
    mode = '{M_EVERY8, M_IDLE, M_IDLE};
    do_reset();
    step(71);
    check("t1_lock_e71", ch_locked, 3'b000);
    check("t1_ph1_e71", phase1, 0);
    step(1);
    check("t1_lock_e72", ch_locked, 3'b001);
    check("t1_ph_e72", {phase0, phase1, phase2}, 12'h011);
    check("t1_all_e72", all_locked, 0);
    step(72);
    check("t1_ph_e144", {phase0, phase1, phase2}, 12'h022);
    check("t1_lock_e144", ch_locked, 3'b001);

    // 2: d1 tokens only at phase 6
    mode = '{M_IDLE, M_PHASE6, M_IDLE};
    do_reset();
    step(431);
    check("t2_ph1_e431", phase1, 5);
    step(1);
    check("t2_ph1_e432", phase1, 6);
    step(71);
    check("t2_lock_e503", ch_locked, 3'b000);
    step(1);
    check("t2_lock_e504", ch_locked, 3'b010);
    check("t2_relock", relock_count, 0);
    step(200);
    check("t2_hold_ph1", phase1, 6);
    check("t2_hold_lock", ch_locked, 3'b010);

    // 3: all lock, then all tokens vanish
    mode = '{M_EVERY8, M_EVERY8, M_EVERY8};
    do_reset();
    step(71);
    check("t3_all_e71", all_locked, 0);
    step(1);
    check("t3_all_e72", {ch_locked, all_locked}, 4'b1111);
    mode = '{M_IDLE, M_IDLE, M_IDLE};
    step(127);
    check("t3_still_e199", {ch_locked, all_locked}, 4'b1111);
    step(1);
    check("t3_drop_e200", {ch_locked, all_locked}, 4'b0000);
    check("t3_ph_e200", {phase0, phase1, phase2}, 12'h111);
    check("t3_relock", relock_count, 3);

    // 4: bad window then good window clears the miss count
    mode = '{M_EVERY8, M_IDLE, M_IDLE};
    do_reset();
    step(72);
    check("t4_lock", ch_locked, 3'b001);
    mode[0] = M_IDLE;   step(64); check("t4_bad1", ch_locked, 3'b001);
    mode[0] = M_EVERY8; step(64); check("t4_good", ch_locked, 3'b001);
    mode[0] = M_IDLE;   step(64); check("t4_bad_again", ch_locked, 3'b001);
    mode[0] = M_EVERY8; step(64);
    check("t4_final", {ch_locked, relock_count, phase0}, {3'b001, 8'd0, 4'd0});
    mode[0] = M_IDLE;
    step(127);
    check("t4_before_drop", ch_locked, 3'b001);
    step(1);
    check("t4_drop", {ch_locked, relock_count, phase0}, {3'b000, 8'd1, 4'd1});

    // 5: token count boundaries
    mode = '{M_P3, M_IDLE, M_IDLE};
    do_reset();
    step(648);
    check("t5_ph0_e648", phase0, 9);
    step(71);
    check("t5_ph0_e719", phase0, 9);
    step(1);
    check("t5_wrap", {ch_locked, phase0}, {3'b000, 4'd0});
    mode = '{M_LIST, M_IDLE, M_IDLE};
    list_e = '{9, 10, 11, 72};
    do_reset();
    step(71);
    check("t5_last_e71", ch_locked, 3'b000);
    step(1);
    check("t5_last_cycle_tok", {ch_locked, phase0}, {3'b001, 4'd0});
    list_e = '{8, 9, 10, 72};
    do_reset();
    step(72);
    check("t5_settle_tok_ignored", {ch_locked, phase0}, {3'b000, 4'd1});

    // 6: enable handling and relock_count saturation
    mode = '{M_EVERY8, M_IDLE, M_IDLE};
    do_reset();
    step(102);
    check("t6_pre", {ch_locked, phase0, phase1}, {3'b001, 4'd0, 4'd1});
    enable = 1'b0;
    step(1);
    check("t6_dis", {ch_locked, all_locked, relock_count}, 12'h0);
    check("t6_dis_ph", {phase0, phase1, phase2}, 12'h011);
    step(20);
    check("t6_dis_hold", {phase0, phase1, phase2, ch_locked}, {12'h011, 3'b000});
    enable = 1'b1;
    mode = '{M_EVERY8, M_EVERY8, M_EVERY8};
    step(71);
    check("t6_reen_e71", ch_locked, 3'b000);
    step(1);
    check("t6_reen_e72", {ch_locked, all_locked}, 4'b1111);
    check("t6_reen_ph", {phase0, phase1, phase2}, 12'h011);
    enable = 1'b0;
    step(1);
    check("t6_dis_locked", {ch_locked, all_locked, relock_count}, 12'h0);
    check("t6_dis_locked_ph", {phase0, phase1, phase2}, 12'h011);
    step(4);
    mode = '{M_UNLOCKED, M_UNLOCKED, M_UNLOCKED};
    enable = 1'b1;
    step(199);
    check("t6_round1_pre", relock_count, 0);
    step(1);
    check("t6_round1", {ch_locked, relock_count}, {3'b000, 8'd3});
    check("t6_round1_ph", {phase0, phase1, phase2}, 12'h122);
    step(200 * 83);
    check("t6_round84", relock_count, 252);
    step(200);
    check("t6_round85", relock_count, 255);
    step(200 * 15);
    check("t6_round100_sat", relock_count, 255);
    check("t6_round100_ph", {phase0, phase1, phase2}, 12'h011);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
